lcd_controller: RTL and testbench



---
 rtl/lcd_controller_pkg.sv | 72 +++++++
 rtl/lcd_controller_nibble_writer.sv | 95 +++++++++
 rtl/lcd_controller.sv | 243 ++++++++++++++++++++++++
 tb/tb_lcd_controller.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lcd_controller_pkg                                           |
// | Description : Shared types, constants and lookup helpers for the           |
// |               HD44780 4-bit character LCD controller.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package lcd_controller_pkg;

  // Sequencing FSM of the controller top.
  typedef enum logic [2:0] {
    ST_PWR_WAIT  = 3'd0,
    ST_INIT_NIB  = 3'd1,
    ST_INIT_WAIT = 3'd2,
    ST_IDLE      = 3'd3,
    ST_HI_NIB    = 3'd4,
    ST_GAP       = 3'd5,
    ST_LO_NIB    = 3'd6,
    ST_BYTE_WAIT = 3'd7
  } lcd_state_e;

  // Nibble writer FSM.
  typedef enum logic [1:0] {
    NW_IDLE  = 2'd0,
    NW_SETUP = 2'd1,
    NW_PULSE = 2'd2
  } nw_state_e;

  // Default timing, in clock cycles at 50 MHz.
  localparam int unsigned DEF_POWERON    = 750000;
  localparam int unsigned DEF_WAIT_4MS   = 205000;
  localparam int unsigned DEF_WAIT_100US = 5000;
  localparam int unsigned DEF_WAIT_40US  = 2000;
  localparam int unsigned DEF_WAIT_CLEAR = 82000;
  localparam int unsigned DEF_SETUP      = 2;
  localparam int unsigned DEF_PULSE      = 12;
  localparam int unsigned DEF_GAP        = 50;
  localparam int unsigned DEF_CNT_W      = 20;

  // Index of the last entry in the init nibble list and the config byte list.
  localparam logic [1:0] INIT_LAST = 2'd3;
  localparam logic [1:0] CFG_LAST  = 2'd3;

  // Commands that need the long execution wait.
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Power-on nibble list: 0x3, 0x3, 0x3, 0x2 (switches the panel to 4-bit mode).
  function automatic logic [3:0] init_nibble(input logic [1:0] idx);
    case (idx)
      2'd3:    return 4'h2;
      default: return 4'h3;
    endcase
  endfunction

  // Configuration bytes: 4-bit/2-line, entry mode inc, display on, clear.
  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  // Clear-display and return-home are the slow instructions.
  function automatic logic is_clear_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME));
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_controller_nibble_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lcd_nibble_writer                                            |
// | Description : Presents one nibble plus RS to the panel, holds it for the   |
// |               setup time, then strobes E high for the pulse time.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lcd_nibble_writer
  import lcd_controller_pkg::*;
#(
  parameter int unsigned P_SETUP = DEF_SETUP,
  parameter int unsigned P_PULSE = DEF_PULSE,
  parameter int unsigned P_CNT_W = DEF_CNT_W
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [3:0] nibble_i,
  input  logic       rs_i,
  output logic       done_o,
  output logic       e_o,
  output logic       rs_o,
  output logic [3:0] data_o
);

  localparam logic [P_CNT_W-1:0] LD_SETUP = P_CNT_W'(P_SETUP - 1);
  localparam logic [P_CNT_W-1:0] LD_PULSE = P_CNT_W'(P_PULSE - 1);
  localparam logic [P_CNT_W-1:0] CNT_ONE  = P_CNT_W'(1);

  nw_state_e          state_q, state_d;
  logic [P_CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]         data_q, data_d;
  logic               rs_q, rs_d;

  // State, counter and bus registers; data/RS are only loaded on start so
  // they hold their last value between nibbles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= NW_IDLE;
      cnt_q   <= '0;
      data_q  <= 4'h0;
      rs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
    end
  end

  // Setup then pulse sequencing. The caller only starts a nibble when the
  // writer is idle, so data never changes while E is high.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rs_d    = rs_q;
    if (start_i) begin
      state_d = NW_SETUP;
      cnt_d   = LD_SETUP;
      data_d  = nibble_i;
      rs_d    = rs_i;
    end else begin
      case (state_q)
        NW_SETUP: begin
          if (cnt_q == '0) begin
            state_d = NW_PULSE;
            cnt_d   = LD_PULSE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        NW_PULSE: begin
          if (cnt_q == '0) begin
            state_d = NW_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = NW_IDLE;
        end
      endcase
    end
  end

  // done is high during the final E-high cycle so the caller can move on
  // on the same edge that drops E.
  assign done_o = (state_q == NW_PULSE) && (cnt_q == '0);
  assign e_o    = (state_q == NW_PULSE);
  assign rs_o   = rs_q;
  assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/lcd_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lcd_controller                                               |
// | Description : HD44780 4-bit LCD sequencer: power-on init, then one byte    |
// |               per ready/valid handshake split into two E-strobed nibbles.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lcd_controller
  import lcd_controller_pkg::*;
#(
  parameter int unsigned P_POWERON    = DEF_POWERON,
  parameter int unsigned P_WAIT_4MS   = DEF_WAIT_4MS,
  parameter int unsigned P_WAIT_100US = DEF_WAIT_100US,
  parameter int unsigned P_WAIT_40US  = DEF_WAIT_40US,
  parameter int unsigned P_WAIT_CLEAR = DEF_WAIT_CLEAR,
  parameter int unsigned P_SETUP      = DEF_SETUP,
  parameter int unsigned P_PULSE      = DEF_PULSE,
  parameter int unsigned P_GAP        = DEF_GAP,
  parameter int unsigned P_CNT_W      = DEF_CNT_W
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iWrite,
  input  logic       iRS,
  input  logic [7:0] iData,
  output logic       oReady,
  output logic       oInitDone,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic [3:0] oLCD_Data
);

  // Counter reload values are length-1: the state advances on the edge
  // where the counter already reads zero.
  localparam logic [P_CNT_W-1:0] LD_POWERON    = P_CNT_W'(P_POWERON - 1);
  localparam logic [P_CNT_W-1:0] LD_WAIT_4MS   = P_CNT_W'(P_WAIT_4MS - 1);
  localparam logic [P_CNT_W-1:0] LD_WAIT_100US = P_CNT_W'(P_WAIT_100US - 1);
  localparam logic [P_CNT_W-1:0] LD_WAIT_40US  = P_CNT_W'(P_WAIT_40US - 1);
  localparam logic [P_CNT_W-1:0] LD_WAIT_CLEAR = P_CNT_W'(P_WAIT_CLEAR - 1);
  localparam logic [P_CNT_W-1:0] LD_GAP        = P_CNT_W'(P_GAP - 1);
  localparam logic [P_CNT_W-1:0] CNT_ONE       = P_CNT_W'(1);

  // Post-nibble wait for each of the four power-on nibbles.
  function automatic logic [P_CNT_W-1:0] init_wait_load(input logic [1:0] idx);
    case (idx)
      2'd0:    return LD_WAIT_4MS;
      2'd1:    return LD_WAIT_100US;
      default: return LD_WAIT_40US;
    endcase
  endfunction

  lcd_state_e         state_q, state_d;
  logic [P_CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic               cfg_q, cfg_d;
  logic [7:0]         byte_q, byte_d;
  logic               rs_q, rs_d;
  logic               init_done_q, init_done_d;

  logic               accept;
  logic               cnt_zero;
  logic [7:0]         cfg_sel;
  logic               nw_start;
  logic [3:0]         nw_nibble;
  logic               nw_rs;
  logic               nw_done;
  logic               nw_e;
  logic               nw_rs_out;
  logic [3:0]         nw_data;

  assign accept   = iWrite && (state_q == ST_IDLE);
  assign cnt_zero = (cnt_q == '0);

  lcd_nibble_writer #(
    .P_SETUP (P_SETUP),
    .P_PULSE (P_PULSE),
    .P_CNT_W (P_CNT_W)
  ) u_nibble_writer (
    .clk_i    (Clock),
    .rst_i    (Reset),
    .start_i  (nw_start),
    .nibble_i (nw_nibble),
    .rs_i     (nw_rs),
    .done_o   (nw_done),
    .e_o      (nw_e),
    .rs_o     (nw_rs_out),
    .data_o   (nw_data)
  );

  // Sequencer registers; reset restarts the whole power-on sequence.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= ST_PWR_WAIT;
      cnt_q       <= LD_POWERON;
      idx_q       <= 2'd0;
      cfg_q       <= 1'b0;
      byte_q      <= 8'h00;
      rs_q        <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      cfg_q       <= cfg_d;
      byte_q      <= byte_d;
      rs_q        <= rs_d;
      init_done_q <= init_done_d;
    end
  end

  // Next-state logic. Each nibble is launched on the same edge that leaves
  // the preceding state, which keeps the byte latency exact.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    cfg_d       = cfg_q;
    byte_d      = byte_q;
    rs_d        = rs_q;
    init_done_d = init_done_q;
    nw_start    = 1'b0;
    nw_nibble   = byte_q[3:0];
    nw_rs       = rs_q;
    cfg_sel     = (state_q == ST_INIT_WAIT) ? cfg_byte(2'd0) : cfg_byte(idx_q + 2'd1);

    case (state_q)
      ST_PWR_WAIT: begin
        if (cnt_zero) begin
          state_d   = ST_INIT_NIB;
          idx_d     = 2'd0;
          nw_start  = 1'b1;
          nw_nibble = init_nibble(2'd0);
          nw_rs     = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_INIT_NIB: begin
        if (nw_done) begin
          state_d = ST_INIT_WAIT;
          cnt_d   = init_wait_load(idx_q);
        end
      end

      ST_INIT_WAIT: begin
        if (cnt_zero) begin
          nw_start = 1'b1;
          nw_rs    = 1'b0;
          if (idx_q == INIT_LAST) begin
            // Init nibbles done: configuration bytes go through the byte path.
            state_d   = ST_HI_NIB;
            idx_d     = 2'd0;
            cfg_d     = 1'b1;
            byte_d    = cfg_sel;
            rs_d      = 1'b0;
            nw_nibble = cfg_sel[7:4];
          end else begin
            state_d   = ST_INIT_NIB;
            idx_d     = idx_q + 2'd1;
            nw_nibble = init_nibble(idx_q + 2'd1);
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_HI_NIB;
          byte_d    = iData;
          rs_d      = iRS;
          nw_start  = 1'b1;
          nw_nibble = iData[7:4];
          nw_rs     = iRS;
        end
      end

      ST_HI_NIB: begin
        if (nw_done) begin
          state_d = ST_GAP;
          cnt_d   = LD_GAP;
        end
      end

      ST_GAP: begin
        if (cnt_zero) begin
          state_d   = ST_LO_NIB;
          nw_start  = 1'b1;
          nw_nibble = byte_q[3:0];
          nw_rs     = rs_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_LO_NIB: begin
        if (nw_done) begin
          state_d = ST_BYTE_WAIT;
          cnt_d   = is_clear_cmd(rs_q, byte_q) ? LD_WAIT_CLEAR : LD_WAIT_40US;
        end
      end

      ST_BYTE_WAIT: begin
        if (cnt_zero) begin
          if (cfg_q && (idx_q != CFG_LAST)) begin
            state_d   = ST_HI_NIB;
            idx_d     = idx_q + 2'd1;
            byte_d    = cfg_sel;
            rs_d      = 1'b0;
            nw_start  = 1'b1;
            nw_nibble = cfg_sel[7:4];
            nw_rs     = 1'b0;
          end else begin
            // Ready and init-done rise together after the final config clear.
            state_d = ST_IDLE;
            if (cfg_q) begin
              cfg_d       = 1'b0;
              init_done_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = ST_PWR_WAIT;
        cnt_d   = LD_POWERON;
      end
    endcase
  end

  assign oReady    = (state_q == ST_IDLE);
  assign oInitDone = init_done_q;
  assign oLCD_E    = nw_e;
  assign oLCD_RS   = nw_rs_out;
  assign oLCD_RW   = 1'b0;
  assign oLCD_Data = nw_data;

endmodule
`default_nettype wire

// File: tb/tb_lcd_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lcd_controller                                            |
// | Description : Scoreboard bench for lcd_controller with a nibble/latency    |
// |               reference model and an independent output monitor.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_lcd_controller;

  localparam int T_POWERON = 20;
  localparam int T_4MS     = 15;
  localparam int T_100US   = 8;
  localparam int T_40US    = 10;
  localparam int T_CLEAR   = 30;
  localparam int T_SETUP   = 2;
  localparam int T_PULSE   = 3;
  localparam int T_GAP     = 4;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       iWrite;
  logic       iRS;
  logic [7:0] iData;
  logic       oReady;
  logic       oInitDone;
  logic       oLCD_E;
  logic       oLCD_RS;
  logic       oLCD_RW;
  logic [3:0] oLCD_Data;

  always #5 Clock = ~Clock;

  lcd_controller #(
    .P_POWERON    (T_POWERON),
    .P_WAIT_4MS   (T_4MS),
    .P_WAIT_100US (T_100US),
    .P_WAIT_40US  (T_40US),
    .P_WAIT_CLEAR (T_CLEAR),
    .P_SETUP      (T_SETUP),
    .P_PULSE      (T_PULSE),
    .P_GAP        (T_GAP),
    .P_CNT_W      (20)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .iWrite    (iWrite),
    .iRS       (iRS),
    .iData     (iData),
    .oReady    (oReady),
    .oInitDone (oInitDone),
    .oLCD_E    (oLCD_E),
    .oLCD_RS   (oLCD_RS),
    .oLCD_RW   (oLCD_RW),
    .oLCD_Data (oLCD_Data)
  );

  typedef struct packed {
    logic [3:0] nib;
    logic       rs;
  } nib_t;

  nib_t exp_nib_q[$];
  int   exp_ready_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   abort  = 1'b0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: a byte costs two setups, two pulses, one gap and a wait
  // that depends on whether it is a clear/home instruction.
  function automatic int byte_lat(input logic rs, input logic [7:0] d);
    int w;
    w = (!rs && (d == 8'h01 || d == 8'h02)) ? T_CLEAR : T_40US;
    return 2 * T_SETUP + 2 * T_PULSE + T_GAP + w;
  endfunction

  task automatic push_nib(input logic [3:0] n, input logic rs);
    nib_t e;
    e.nib = n;
    e.rs  = rs;
    exp_nib_q.push_back(e);
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] d);
    push_nib(d[7:4], rs);
    push_nib(d[3:0], rs);
  endtask

  // Called at the negedge on which Reset is released: the last reset edge is
  // posedge number cyc.
  task automatic push_init();
    int         t;
    int         waits [4];
    logic [3:0] nibs  [4];
    logic [7:0] cfg   [4];
    waits = '{T_4MS, T_100US, T_40US, T_40US};
    nibs  = '{4'h3, 4'h3, 4'h3, 4'h2};
    cfg   = '{8'h28, 8'h06, 8'h0C, 8'h01};
    t = T_POWERON;
    for (int i = 0; i < 4; i++) begin
      push_nib(nibs[i], 1'b0);
      t += T_SETUP + T_PULSE + waits[i];
    end
    for (int i = 0; i < 4; i++) begin
      push_byte(1'b0, cfg[i]);
      t += byte_lat(1'b0, cfg[i]);
    end
    exp_ready_q.push_back(cyc + t);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_E"}, oLCD_E, 0);
    chk({tag, "_RS"}, oLCD_RS, 0);
    chk({tag, "_RW"}, oLCD_RW, 0);
    chk({tag, "_Data"}, oLCD_Data, 0);
    chk({tag, "_Ready"}, oReady, 0);
    chk({tag, "_InitDone"}, oInitDone, 0);
  endtask

  // Returns at a negedge where oReady is high, or flags a timeout.
  task automatic wait_ready();
    int n;
    n = 0;
    while (!oReady && n < 2000) begin
      @(negedge Clock);
      n++;
    end
    if (!oReady) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got 0 expected 1 within 2000 cycles");
    end
  endtask

  task automatic write_byte(input logic rs, input logic [7:0] d);
    int acc;
    wait_ready();
    if (oReady) begin
      iWrite = 1'b1;
      iRS    = rs;
      iData  = d;
      acc    = cyc + 1;
      push_byte(rs, d);
      exp_ready_q.push_back(acc + byte_lat(rs, d));
      @(negedge Clock);
      iWrite = 1'b0;
      iData  = 8'($urandom);
      iRS    = 1'($urandom);
      chk("ready_drop", oReady, 0);
    end
  endtask

  // Write requests while busy must be dropped, not queued.
  task automatic busy_poke();
    iWrite = 1'b1;
    iData  = 8'($urandom);
    iRS    = 1'($urandom);
    repeat (3) @(negedge Clock);
    iWrite = 1'b0;
  endtask

  // Output monitor: pops one expected nibble per E rising edge and one
  // expected cycle per oReady rising edge.
  nib_t       mon_e;
  logic       prev_e    = 1'b0;
  logic       prev_rdy  = 1'b0;
  logic       prev_done = 1'b0;
  int         width     = 0;
  logic [3:0] hold_d    = 4'h0;
  logic       hold_rs   = 1'b0;

  initial begin
    forever begin
      @(negedge Clock);
      if (oLCD_E && !prev_e) begin
        width   = 1;
        hold_d  = oLCD_Data;
        hold_rs = oLCD_RS;
        if (exp_nib_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got nibble %0h rs %0b expected none", oLCD_Data, oLCD_RS);
        end else begin
          mon_e = exp_nib_q.pop_front();
          chk("nibble", oLCD_Data, mon_e.nib);
          chk("nibble_rs", oLCD_RS, mon_e.rs);
        end
      end else if (oLCD_E) begin
        width++;
        chk("stable_data_high", oLCD_Data, hold_d);
        chk("stable_rs_high", oLCD_RS, hold_rs);
      end else if (prev_e && !abort && !Reset) begin
        chk("pulse_width", width, T_PULSE);
        chk("stable_data_fall", oLCD_Data, hold_d);
        chk("stable_rs_fall", oLCD_RS, hold_rs);
      end

      if (oReady && !prev_rdy) begin
        if (exp_ready_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: got rise at cycle %0d expected none", cyc);
        end else begin
          chk("ready_cycle", cyc, exp_ready_q.pop_front());
        end
        chk("initdone_at_ready", oInitDone, 1);
      end
      if (oInitDone && !prev_done) begin
        chk("ready_at_initdone", oReady, 1);
      end

      prev_e    = oLCD_E;
      prev_rdy  = oReady;
      prev_done = oInitDone;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int   rises;
  logic pe;
  int   n;
  int   acc1;
  logic r_rs;
  logic [7:0] r_d;

  initial begin
    Reset  = 1'b1;
    iWrite = 1'b0;
    iRS    = 1'b0;
    iData  = 8'h00;
    repeat (3) @(negedge Clock);
    check_zero_outputs("reset");
    push_init();
    Reset = 1'b0;

    // Requests during power-on wait are ignored.
    repeat (2) @(negedge Clock);
    iWrite = 1'b1;
    iData  = 8'($urandom);
    iRS    = 1'($urandom);
    repeat (8) @(negedge Clock);
    iWrite = 1'b0;
    wait_ready();

    write_byte(1'b1, 8'h48);
    write_byte(1'b0, 8'h01);

    // Request held through a busy byte: the second value is taken on the
    // first edge where oReady is high again, and nothing else.
    wait_ready();
    iWrite = 1'b1;
    iRS    = 1'b1;
    iData  = 8'h4F;
    acc1   = cyc + 1;
    push_byte(1'b1, 8'h4F);
    exp_ready_q.push_back(acc1 + byte_lat(1'b1, 8'h4F));
    repeat (8) @(negedge Clock);
    iData = 8'h4C;
    push_byte(1'b1, 8'h4C);
    exp_ready_q.push_back(acc1 + byte_lat(1'b1, 8'h4F) + 1 + byte_lat(1'b1, 8'h4C));
    wait_ready();
    @(negedge Clock);
    iWrite = 1'b0;
    iData  = 8'($urandom);
    chk("held_second_accept", oReady, 0);

    // Randomized traffic, biased towards the slow clear/home commands.
    for (int i = 0; i < 20; i++) begin
      r_rs = 1'($urandom);
      r_d  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        r_rs = 1'b0;
        r_d  = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
      end
      repeat ($urandom_range(0, 4)) @(negedge Clock);
      write_byte(r_rs, r_d);
      if ($urandom_range(0, 2) == 0) busy_poke();
    end

    // Reset while E is high on the low nibble.
    write_byte(1'b1, 8'($urandom));
    rises = 0;
    pe    = oLCD_E;
    n     = 0;
    while (rises < 2 && n < 200) begin
      @(negedge Clock);
      if (oLCD_E && !pe) rises++;
      pe = oLCD_E;
      n++;
    end
    chk("lo_pulse_found", rises, 2);
    Reset = 1'b1;
    abort = 1'b1;
    @(negedge Clock);
    check_zero_outputs("midreset");
    exp_nib_q.delete();
    exp_ready_q.delete();
    repeat (2) @(negedge Clock);
    push_init();
    Reset = 1'b0;
    abort = 1'b0;
    repeat (5) @(negedge Clock);
    chk("initdone_low_after_reset", oInitDone, 0);

    write_byte(1'b1, 8'($urandom));
    write_byte(1'b0, 8'h02);
    wait_ready();
    repeat (5) @(negedge Clock);
    chk("nibble_queue_empty", exp_nib_q.size(), 0);
    chk("ready_queue_empty", exp_ready_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
